operand_stack: RTL

OPERAND_STACK -- requirements
Module: operand_stack

---
 rtl/operand_stack_if.sv | 28 ++
 rtl/operand_stack.sv | 113 +++++++++++
 2 files changed

// File: rtl/operand_stack_if.sv
// Controller <-> operand stack bus: strobe, op request, push data and stack status.
interface operand_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             stack_clk;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_to_push;
    logic [WIDTH-1:0] data_from_stack;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output stack_clk, push, pop, data_to_push,
        input  data_from_stack, count, empty, full, overflow, underflow
    );

    modport slave (
        input  stack_clk, push, pop, data_to_push,
        output data_from_stack, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack driven by a strobe edge; top-of-stack is kept in a register.
// Define STACK_STICKY_ERR_EN to make overflow/underflow sticky until reset/rst.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic              clk,
    input logic              reset,
    input logic              rst,
    operand_stack_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef STACK_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];

    logic             stack_clk_q;
    logic             arm_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             op_fire;
    logic             empty, full;
    logic [CW-1:0]    cnt_m1, cnt_m2;
    logic             we;
    logic [AW-1:0]    wr_idx;

    // arm_q blocks a strobe that is already high when reset releases
    assign op_fire = bus.stack_clk & ~stack_clk_q & arm_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign cnt_m1  = count_q - CW'(1);
    assign cnt_m2  = count_q - CW'(2);

    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        we      = 1'b0;
        wr_idx  = count_q[AW-1:0];
        ovf_d   = STICKY ? ovf_q : 1'b0;
        unf_d   = STICKY ? unf_q : 1'b0;
        if (op_fire) begin
            if (bus.push && (!bus.pop || empty)) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    wr_idx  = count_q[AW-1:0];
                    count_d = count_q + CW'(1);
                    top_d   = bus.data_to_push;
                end
            end else if (bus.push && bus.pop) begin
                we     = 1'b1;
                wr_idx = cnt_m1[AW-1:0];
                top_d  = bus.data_to_push;
            end else if (bus.pop) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = cnt_m1;
                    top_d   = (count_q == CW'(1)) ? '0 : mem[cnt_m2[AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_clk_q <= 1'b0;
            arm_q       <= 1'b0;
            count_q     <= '0;
            top_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (rst) begin
            stack_clk_q <= 1'b0;
            arm_q       <= ~bus.stack_clk;
            count_q     <= '0;
            top_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            stack_clk_q <= bus.stack_clk;
            if (!bus.stack_clk)
                arm_q <= 1'b1;
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is never cleared; count alone decides which entries are live
    always_ff @(posedge clk) begin
        if (we && !rst && !reset)
            mem[wr_idx] <= bus.data_to_push;
    end

    assign bus.data_from_stack = top_q;
    assign bus.count           = count_q;
    assign bus.empty           = empty;
    assign bus.full            = full;
    assign bus.overflow        = ovf_q;
    assign bus.underflow       = unf_q;
endmodule
